ram_dp_init: RTL and testbench

- Parametrised simple-dual-port synchronous RAM: one write port, one read port, single clock.
- Generalises the 16x8 RAM in data width, address width and depth.
- Adds a registered read-valid strobe and a selectable read-during-write collision mode.
- Adds a hardware clear sequencer that fills every word with INIT_VAL after reset, plus a drop flag for rejected accesses. Serves as the storage primitive for FIFOs and register-file blocks.

---
 rtl/ram_dp_init.sv | 103 ++++++++++
 tb/tb_ram_dp_init.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_init.sv
// Simple-dual-port synchronous RAM with a registered read port, a configurable
// read-during-write collision mode and a post-reset hardware clear sequencer.
module ram_dp_init #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 4,
  parameter int unsigned       DEPTH    = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter bit                BYPASS   = 1'b1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              wen,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ren,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              init_busy,
  output logic              drop
);

  localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_clr_we;
  logic                w_w_inrange;
  logic                w_r_inrange;
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic                w_reject;
  logic                w_collide;
  logic [IDX_W-1:0]    w_widx;
  logic [IDX_W-1:0]    w_ridx;
  logic [IDX_W-1:0]    w_cidx;
  logic [DATA_W-1:0]   w_rd_data;

  // Access qualification: clear owns the array until every word is written.
  always_comb begin
    w_w_inrange = ({1'b0, w_addr} < DEPTH_X);
    w_r_inrange = ({1'b0, r_addr} < DEPTH_X);
    w_clr_we    = !rst && (r_state == ST_CLEAR);
    w_wr_ok     = !rst && (r_state == ST_READY) && wen && w_w_inrange;
    w_rd_ok     = !rst && (r_state == ST_READY) && ren && w_r_inrange;
    w_reject    = !rst && (((r_state == ST_CLEAR) && (wen || ren)) ||
                           ((r_state == ST_READY) &&
                            ((wen && !w_w_inrange) || (ren && !w_r_inrange))));
    w_widx      = IDX_W'(w_addr);
    w_ridx      = IDX_W'(r_addr);
    w_cidx      = IDX_W'(r_cnt);
    w_collide   = BYPASS && w_wr_ok && (w_addr == r_addr);
    w_rd_data   = w_collide ? wr_data : r_mem[w_ridx];
  end

  // Storage array: no reset, contents come from the clear sequence.
  always_ff @(posedge clock) begin
    if (w_clr_we) begin
      r_mem[w_cidx] <= INIT_VAL;
    end else if (w_wr_ok) begin
      r_mem[w_widx] <= wr_data;
    end
  end

  // Clear sequencer and registered read/status outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_cnt     <= '0;
      init_busy <= 1'b1;
      dout      <= '0;
      rd_valid  <= 1'b0;
      drop      <= 1'b0;
    end else begin
      drop     <= w_reject;
      rd_valid <= w_rd_ok;
      if (w_rd_ok) begin
        dout <= w_rd_data;
      end
      case (r_state)
        ST_CLEAR: begin
          if (r_cnt == LAST) begin
            r_state   <= ST_READY;
            r_cnt     <= '0;
            init_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        default: begin
          r_state <= ST_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dp_init.sv
// Self-checking bench: two RAM instances (16 words write-first, 12 words
// read-first with non-zero init) driven by shared directed stimulus.
module tb_ram_dp_init;

  localparam int NI = 2;

  logic       clock = 1'b0;
  logic       rst, wen, ren;
  logic [3:0] w_addr, r_addr;
  logic [7:0] wr_data;

  logic [7:0] dout0, dout1;
  logic       rv0, rv1, busy0, busy1, drop0, drop1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  ram_dp_init #(
    .DATA_W(8), .ADDR_W(4), .DEPTH(16), .INIT_VAL(8'h00), .BYPASS(1'b1)
  ) u_dut0 (
    .clock(clock), .rst(rst), .wen(wen), .w_addr(w_addr), .wr_data(wr_data),
    .ren(ren), .r_addr(r_addr), .dout(dout0), .rd_valid(rv0),
    .init_busy(busy0), .drop(drop0)
  );

  ram_dp_init #(
    .DATA_W(8), .ADDR_W(4), .DEPTH(12), .INIT_VAL(8'h3C), .BYPASS(1'b0)
  ) u_dut1 (
    .clock(clock), .rst(rst), .wen(wen), .w_addr(w_addr), .wr_data(wr_data),
    .ren(ren), .r_addr(r_addr), .dout(dout1), .rd_valid(rv1),
    .init_busy(busy1), .drop(drop1)
  );

  // Reference model: clearing is a countdown of edges; the array is filled with
  // the init value when the countdown expires (it is unobservable before that).
  int unsigned p_depth [NI] = '{16, 12};
  bit          p_byp   [NI] = '{1'b1, 1'b0};
  logic [7:0]  p_init  [NI] = '{8'h00, 8'h3C};

  logic [7:0]  m_mem  [NI][16];
  int          m_left [NI];
  logic [7:0]  e_dout [NI];
  logic        e_rv   [NI];
  logic        e_busy [NI];
  logic        e_drop [NI];
  bit          live = 1'b0;

  always @(posedge clock) begin
    bit ok_w, ok_r;
    if (rst) live = 1'b1;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_left[k] = int'(p_depth[k]);
        e_busy[k] = 1'b1;
        e_dout[k] = 8'h00;
        e_rv[k]   = 1'b0;
        e_drop[k] = 1'b0;
      end else if (m_left[k] > 0) begin
        e_drop[k] = wen || ren;
        e_rv[k]   = 1'b0;
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) begin
          for (int a = 0; a < 16; a++) m_mem[k][a] = p_init[k];
          e_busy[k] = 1'b0;
        end
      end else begin
        ok_w      = wen && (int'(w_addr) < int'(p_depth[k]));
        ok_r      = ren && (int'(r_addr) < int'(p_depth[k]));
        e_drop[k] = (wen && !ok_w) || (ren && !ok_r);
        e_rv[k]   = ok_r;
        if (ok_r)
          e_dout[k] = (p_byp[k] && ok_w && (w_addr == r_addr)) ? wr_data : m_mem[k][r_addr];
        if (ok_w) m_mem[k][w_addr] = wr_data;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (live) begin
      chk("dout0",  32'(dout0), 32'(e_dout[0]));
      chk("rv0",    32'(rv0),   32'(e_rv[0]));
      chk("busy0",  32'(busy0), 32'(e_busy[0]));
      chk("drop0",  32'(drop0), 32'(e_drop[0]));
      chk("dout1",  32'(dout1), 32'(e_dout[1]));
      chk("rv1",    32'(rv1),   32'(e_rv[1]));
      chk("busy1",  32'(busy1), 32'(e_busy[1]));
      chk("drop1",  32'(drop1), 32'(e_drop[1]));
    end
  end

  task automatic op(input bit we, input logic [3:0] wa, input logic [7:0] wd,
                    input bit re, input logic [3:0] ra);
    wen = we; w_addr = wa; wr_data = wd; ren = re; r_addr = ra;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; ren = 1'b0; w_addr = '0; r_addr = '0; wr_data = '0;
    @(negedge clock); @(negedge clock);
    chk("lit_rst_busy0", 32'(busy0), 32'd1);
    chk("lit_rst_dout0", 32'(dout0), 32'h00);
    chk("lit_rst_rv0",   32'(rv0),   32'd0);
    chk("lit_rst_drop1", 32'(drop1), 32'd0);

    // Clear run interrupted: rejected write on edge 5, reset on edge 8.
    rst = 1'b0;
    idle(4);
    op(1'b1, 4'd2, 8'h7E, 1'b0, 4'd0);
    chk("lit_clr_drop0", 32'(drop0), 32'd1);
    chk("lit_clr_drop1", 32'(drop1), 32'd1);
    idle(1);
    chk("lit_clr_drop_end", 32'(drop0), 32'd0);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("lit_restart_busy", 32'(busy0), 32'd1);
    idle(11);
    chk("lit_busy1_e11", 32'(busy1), 32'd1);
    idle(1);
    chk("lit_busy1_e12", 32'(busy1), 32'd0);
    chk("lit_busy0_e12", 32'(busy0), 32'd1);
    idle(3);
    chk("lit_busy0_e15", 32'(busy0), 32'd1);
    idle(1);
    chk("lit_busy0_e16", 32'(busy0), 32'd0);

    // Read every address after clear.
    for (int a = 0; a < 16; a++) begin
      op(1'b0, 4'd0, 8'h00, 1'b1, 4'(a));
      chk($sformatf("lit_init_rd0_%0d", a), 32'(dout0), 32'h00);
      chk($sformatf("lit_init_rv0_%0d", a), 32'(rv0), 32'd1);
      if (a < 12) chk($sformatf("lit_init_rd1_%0d", a), 32'(dout1), 32'h3C);
      else        chk($sformatf("lit_oor_drop1_%0d", a), 32'(drop1), 32'd1);
    end
    idle(1);
    chk("lit_rv0_idle", 32'(rv0), 32'd0);

    // Write then read back, then hold.
    op(1'b1, 4'd9, 8'hA5, 1'b0, 4'd0);
    op(1'b0, 4'd0, 8'h00, 1'b1, 4'd9);
    chk("lit_a5_dout0", 32'(dout0), 32'hA5);
    chk("lit_a5_rv0",   32'(rv0),   32'd1);
    chk("lit_a5_dout1", 32'(dout1), 32'hA5);
    idle(1);
    chk("lit_a5_hold",  32'(dout0), 32'hA5);
    chk("lit_a5_rvlo",  32'(rv0),   32'd0);

    // Collision: write-first vs read-first.
    op(1'b1, 4'd3, 8'h11, 1'b0, 4'd0);
    op(1'b1, 4'd3, 8'h22, 1'b1, 4'd3);
    chk("lit_coll_wf", 32'(dout0), 32'h22);
    chk("lit_coll_rf", 32'(dout1), 32'h11);
    op(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    chk("lit_coll_after0", 32'(dout0), 32'h22);
    chk("lit_coll_after1", 32'(dout1), 32'h22);

    // Address 13: in range for 16 words, out of range for 12.
    op(1'b1, 4'd13, 8'h7E, 1'b0, 4'd0);
    chk("lit_w13_drop1", 32'(drop1), 32'd1);
    chk("lit_w13_drop0", 32'(drop0), 32'd0);
    op(1'b0, 4'd0, 8'h00, 1'b1, 4'd13);
    chk("lit_r13_dout0", 32'(dout0), 32'h7E);
    chk("lit_r13_rv1",   32'(rv1),   32'd0);
    chk("lit_r13_drop1", 32'(drop1), 32'd1);
    chk("lit_r13_dout1", 32'(dout1), 32'h22);
    op(1'b1, 4'd11, 8'h66, 1'b0, 4'd0);
    op(1'b0, 4'd0, 8'h00, 1'b1, 4'd11);
    chk("lit_r11_dout1", 32'(dout1), 32'h66);
    chk("lit_r11_drop1", 32'(drop1), 32'd0);

    // Independent read and write on different addresses.
    op(1'b1, 4'd4, 8'h99, 1'b1, 4'd9);
    chk("lit_indep_dout1", 32'(dout1), 32'hA5);
    op(1'b0, 4'd0, 8'h00, 1'b1, 4'd4);
    chk("lit_indep_rd4", 32'(dout0), 32'h99);

    // Reset while ready re-clears the array.
    op(1'b1, 4'd5, 8'h55, 1'b0, 4'd0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(16);
    op(1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
    chk("lit_reclr_dout0", 32'(dout0), 32'h00);
    chk("lit_reclr_dout1", 32'(dout1), 32'h3C);

    // Mixed traffic including a mid-run reset, checked by the model only.
    for (int i = 0; i < 80; i++) begin
      rst = (i == 30);
      op(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom),
         1'($urandom_range(0, 1)), 4'($urandom));
    end
    rst = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
